// File: rtl/subline_sequencer_pkg.sv
// Shared definitions for the subline sequencer: default geometry and FSM states.
package subline_sequencer_pkg;

  localparam int DEF_CHAR_W  = 8;   // columns per character
  localparam int DEF_CHAR_H  = 16;  // bits per column
  localparam int DEF_CPSBLN  = 16;  // characters per subline
  localparam int DEF_NUM_SL  = 3;   // sublines per line
  localparam int DEF_GAP_CYC = 4;   // idle cycles after each subline

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_GAP    = 2'd2
  } state_t;

endpackage

// File: rtl/subline_sequencer_skid_buffer2.sv
// Two-entry FIFO holding column data plus its char/col indices.
// The head is always presented on dout, so it holds still while not popped.
module skid_buffer2 #(
  parameter int W = 23
)(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic [1:0]   occ
);

  logic [1:0][W-1:0] mem;
  logic              rd_ptr;
  logic              wr_ptr;
  logic [1:0]        cnt;

  // Storage, pointers and occupancy; push and pop may coincide.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem    <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      cnt <= cnt + 2'(push) - 2'(pop);
    end
  end

  assign dout  = mem[rd_ptr];
  assign valid = (cnt != 2'd0);
  assign occ   = cnt;

endmodule

// File: rtl/subline_sequencer.sv
// Streams NUM_SL sublines from the ROM bank onto one column bus with
// valid/ready flow control. Only the ROM of the current subline is advanced.
module subline_sequencer
  import subline_sequencer_pkg::*;
#(
  parameter int CHAR_W  = DEF_CHAR_W,
  parameter int CHAR_H  = DEF_CHAR_H,
  parameter int CPSBLN  = DEF_CPSBLN,
  parameter int NUM_SL  = DEF_NUM_SL,
  parameter int GAP_CYC = DEF_GAP_CYC
)(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       pause,
  input  logic [NUM_SL*CHAR_H-1:0]   sl_data,
  output logic [NUM_SL-1:0]          rom_en,
  output logic                       rom_rewind,
  output logic [CHAR_H-1:0]          col_out,
  output logic                       col_valid,
  input  logic                       col_ready,
  output logic [1:0]                 sl_sel,
  output logic [$clog2(CPSBLN)-1:0]  char_idx,
  output logic [$clog2(CHAR_W)-1:0]  col_idx,
  output logic                       line_done,
  output logic                       busy
);

  localparam int CI_W  = $clog2(CPSBLN);
  localparam int XI_W  = $clog2(CHAR_W);
  localparam int IDX_W = CI_W + XI_W;
  localparam int COLS  = CPSBLN * CHAR_W;
  localparam int ISS_W = $clog2(COLS + 1);
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  state_t             state;
  logic [ISS_W-1:0]   issued;
  logic               in_flight;
  logic [CI_W-1:0]    fch_char;
  logic [XI_W-1:0]    fch_col;
  logic [IDX_W-1:0]   fly_idx;
  logic [GAP_W-1:0]   gap_cnt;

  logic [1:0]         occ;
  logic               accept;
  logic               fetch;
  logic               last_col;
  logic               gap_done;
  logic               last_sl;
  logic               advance;
  logic [CHAR_H-1:0]  cur_data;
  logic [CHAR_H+IDX_W-1:0] head;

  assign accept   = col_valid & col_ready;
  assign last_col = accept && (int'(char_idx) == CPSBLN-1) && (int'(col_idx) == CHAR_W-1);
  assign gap_done = (int'(gap_cnt) >= GAP_CYC-1);
  assign last_sl  = (int'(sl_sel) == NUM_SL-1);
  assign advance  = (state == S_STREAM && last_col && GAP_CYC == 0) ||
                    (state == S_GAP && gap_done);
  assign line_done = last_col;

  // Fetch gate: a column accepted this cycle frees its slot, so a full-rate
  // stream keeps one entry buffered and one in flight.
  always_comb begin
    fetch = (state == S_STREAM) && !pause && (int'(issued) < COLS) &&
            (int'(occ) - int'(accept) + int'(in_flight) < 2);
    rom_en = '0;
    for (int k = 0; k < NUM_SL; k++)
      rom_en[k] = fetch && (int'(sl_sel) == k);
  end

  // Select the ROM output of the current subline for capture.
  always_comb begin
    cur_data = '0;
    for (int k = 0; k < NUM_SL; k++)
      if (int'(sl_sel) == k) cur_data = sl_data[k*CHAR_H +: CHAR_H];
  end

  // Line FSM with fetch bookkeeping; registered rom_rewind, busy and sl_sel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      sl_sel     <= 2'd0;
      busy       <= 1'b0;
      rom_rewind <= 1'b0;
      issued     <= '0;
      in_flight  <= 1'b0;
      fch_char   <= '0;
      fch_col    <= '0;
      fly_idx    <= '0;
      gap_cnt    <= '0;
    end else begin
      rom_rewind <= 1'b0;
      in_flight  <= fetch;
      if (fetch) begin
        fly_idx <= {fch_char, fch_col};
        issued  <= issued + ISS_W'(1);
        if (int'(fch_col) == CHAR_W-1) begin
          fch_col  <= '0;
          fch_char <= (int'(fch_char) == CPSBLN-1) ? '0 : fch_char + CI_W'(1);
        end else begin
          fch_col <= fch_col + XI_W'(1);
        end
      end
      case (state)
        S_IDLE: if (start) begin
          state      <= S_STREAM;
          rom_rewind <= 1'b1;
          busy       <= 1'b1;
          sl_sel     <= 2'd0;
          issued     <= '0;
          fch_char   <= '0;
          fch_col    <= '0;
        end
        S_STREAM: if (last_col && GAP_CYC != 0) begin
          state   <= S_GAP;
          gap_cnt <= '0;
        end
        S_GAP: if (!gap_done) gap_cnt <= gap_cnt + GAP_W'(1);
        default: state <= S_IDLE;
      endcase
      // End of gap (or end of subline when there is no gap).
      if (advance) begin
        if (last_sl) begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end else begin
          state    <= S_STREAM;
          sl_sel   <= sl_sel + 2'd1;
          issued   <= '0;
          fch_char <= '0;
          fch_col  <= '0;
        end
      end
    end
  end

  skid_buffer2 #(.W(CHAR_H + IDX_W)) u_skid (
    .clk   (clk),
    .rst   (rst),
    .push  (in_flight),
    .din   ({cur_data, fly_idx}),
    .pop   (accept),
    .dout  (head),
    .valid (col_valid),
    .occ   (occ)
  );

  assign col_out  = head[CHAR_H+IDX_W-1:IDX_W];
  assign char_idx = head[IDX_W-1:XI_W];
  assign col_idx  = head[XI_W-1:0];

endmodule

// File: tb/tb_subline_sequencer.sv
// Bench for subline_sequencer: two instances (gap 4 and gap 0) fed by a
// behavioural ROM model returning {subline, column#}; columns are checked
// against the expected line order n = sl*128 + char*8 + col.
module tb_subline_sequencer;
  import subline_sequencer_pkg::*;

  localparam int CHAR_W = 8;
  localparam int CPSBLN = 16;
  localparam int NSL    = 3;
  localparam int COLS   = CHAR_W * CPSBLN;
  localparam int LINE   = COLS * NSL;

  logic clk = 1'b0;
  logic rst, start, pause, col_ready;

  logic [47:0] sl_data    [2];
  logic [2:0]  rom_en     [2];
  logic        rom_rewind [2];
  logic [15:0] col_out    [2];
  logic        col_valid  [2];
  logic [1:0]  sl_sel     [2];
  logic [3:0]  char_idx   [2];
  logic [2:0]  col_idx    [2];
  logic        line_done  [2];
  logic        busy       [2];

  int ntests = 0;
  int nfail  = 0;
  int cyc    = 0;
  int expn [2];
  int acc  [2];
  int ldn  [2];
  int ldc  [2];
  int psl  [2];
  bit pend [2];
  bit stl  [2];
  logic [24:0] held [2];

  always #5 clk = ~clk;

  subline_sequencer #(.GAP_CYC(4)) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .sl_data(sl_data[0]),
    .rom_en(rom_en[0]), .rom_rewind(rom_rewind[0]), .col_out(col_out[0]),
    .col_valid(col_valid[0]), .col_ready(col_ready), .sl_sel(sl_sel[0]),
    .char_idx(char_idx[0]), .col_idx(col_idx[0]), .line_done(line_done[0]),
    .busy(busy[0]));

  subline_sequencer #(.GAP_CYC(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .sl_data(sl_data[1]),
    .rom_en(rom_en[1]), .rom_rewind(rom_rewind[1]), .col_out(col_out[1]),
    .col_valid(col_valid[1]), .col_ready(col_ready), .sl_sel(sl_sel[1]),
    .char_idx(char_idx[1]), .col_idx(col_idx[1]), .line_done(line_done[1]),
    .busy(busy[1]));

  // ROM model: one-cycle read latency, address advances on rom_en,
  // rewind returns to column 0 (a read in the rewind cycle reads column 0).
  logic [11:0] addr [2][3] = '{default: '0};
  logic [15:0] q    [2][3] = '{default: '0};
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 3; k++) begin
        if (rom_en[i][k]) begin
          q[i][k]    <= {4'(k), (rom_rewind[i] ? 12'd0 : addr[i][k])};
          addr[i][k] <= (rom_rewind[i] ? 12'd0 : addr[i][k]) + 12'd1;
        end else if (rom_rewind[i]) begin
          addr[i][k] <= 12'd0;
        end
      end
  end
  assign sl_data[0] = {q[0][2], q[0][1], q[0][0]};
  assign sl_data[1] = {q[1][2], q[1][1], q[1][0]};

  // Expected {col_out, sl_sel, char_idx, col_idx} of the n-th column of a line.
  function automatic logic [24:0] exp_col(int n);
    int sl = n / COLS;
    int c  = n % COLS;
    return {4'(sl), 12'(c), 2'(sl), 4'(c / CHAR_W), 3'(c % CHAR_W)};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: monitor both DUTs at the falling edge, then advance.
  task automatic cycle();
    logic [24:0] obs;
    @(negedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) begin
      obs = {col_out[i], sl_sel[i], char_idx[i], col_idx[i]};
      if (stl[i]) begin
        chk("stall_valid", 32'(col_valid[i]), 1);
        chk("stall_hold", 32'(obs), 32'(held[i]));
      end
      if (pend[i] && rom_en[i] != 3'b000) begin
        chk("gap_len", cyc - ldc[i], (i == 0) ? 5 : 1);
        chk("next_sl_en", 32'(rom_en[i]), 32'(3'b001 << psl[i]));
        pend[i] = 1'b0;
      end
      if (col_valid[i] && col_ready) begin
        chk("col", 32'(obs), 32'(exp_col(expn[i])));
        chk("line_done", 32'(line_done[i]), 32'((expn[i] % COLS) == COLS-1));
        if (line_done[i]) begin
          ldn[i]++;
          if (expn[i] / COLS < NSL-1) begin
            pend[i] = 1'b1;
            ldc[i]  = cyc;
            psl[i]  = expn[i] / COLS + 1;
          end
        end
        expn[i]++;
        acc[i]++;
        stl[i] = 1'b0;
      end else begin
        chk("line_done_idle", 32'(line_done[i]), 0);
        stl[i]  = col_valid[i];
        held[i] = obs;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_track();
    for (int i = 0; i < 2; i++) begin
      expn[i] = 0; ldn[i] = 0; pend[i] = 1'b0; stl[i] = 1'b0;
    end
  endtask

  // Pulse start for one cycle; returns in cycle 0 (rom_rewind cycle).
  task automatic do_start();
    clear_track();
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("rewind", 32'(rom_rewind[i]), 1);
      chk("busy_start", 32'(busy[i]), 1);
      chk("first_en", 32'(rom_en[i]), 32'b001);
    end
  endtask

  task automatic run_until(int n, bit rnd);
    int b = 0;
    while (expn[0] < n && b < 3000) begin
      if (rnd) col_ready = 1'($urandom_range(0, 1));
      cycle();
      b++;
    end
    chk("reach", 32'(expn[0] >= n), 1);
  endtask

  task automatic run_to_idle(bit rnd);
    int b = 0;
    while ((busy[0] || busy[1] || col_valid[0] || col_valid[1]) && b < 3000) begin
      if (rnd) col_ready = 1'($urandom_range(0, 1));
      cycle();
      b++;
    end
    col_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      chk("idle_busy", 32'(busy[i]), 0);
      chk("ncols", expn[i], LINE);
      chk("nlines", ldn[i], NSL);
    end
  endtask

  initial begin
    int a0 [2];
    rst = 1'b0; start = 1'b0; pause = 1'b0; col_ready = 1'b0;
    clear_track();
    acc[0] = 0; acc[1] = 0;
    repeat (3) cycle();
    for (int i = 0; i < 2; i++) begin
      chk("rst_rom_en", 32'(rom_en[i]), 0);
      chk("rst_rewind", 32'(rom_rewind[i]), 0);
      chk("rst_valid", 32'(col_valid[i]), 0);
      chk("rst_col", {col_out[i], sl_sel[i], char_idx[i], col_idx[i], busy[i], line_done[i]}, 0);
    end
    rst = 1'b1;
    cycle();

    // 1: full line at full rate; 2-cycle startup, gaps, three line_done.
    col_ready = 1'b1;
    do_start();
    cycle();
    chk("cyc1_valid", 32'(col_valid[0]), 0);
    chk("cyc1_rewind", 32'(rom_rewind[0]), 0);
    cycle();
    chk("cyc2_valid", 32'(col_valid[0]), 1);
    chk("cyc2_valid_g0", 32'(col_valid[1]), 1);
    run_to_idle(1'b0);

    // 2: random backpressure.
    do_start();
    run_to_idle(1'b1);

    // 3: pause mid-subline drains at most two columns.
    do_start();
    run_until(150, 1'b0);
    pause = 1'b1;
    a0[0] = acc[0]; a0[1] = acc[1];
    repeat (10) cycle();
    for (int i = 0; i < 2; i++) begin
      chk("pause_drain", 32'((acc[i] - a0[i]) <= 2), 1);
      chk("pause_valid", 32'(col_valid[i]), 0);
    end
    pause = 1'b0;
    run_to_idle(1'b0);

    // 4: start held into the rewind cycle and pulsed again mid-line.
    clear_track();
    start = 1'b1;
    cycle();
    chk("rewind4", 32'(rom_rewind[0]), 1);
    cycle();
    start = 1'b0;
    chk("rewind_ign", 32'(rom_rewind[0]), 0);
    run_until(40, 1'b0);
    start = 1'b1;
    cycle();
    start = 1'b0;
    chk("busy_start_ign", 32'(rom_rewind[0] | rom_rewind[1]), 0);
    run_to_idle(1'b0);

    // 5: async reset mid-subline 1, then a clean restart.
    do_start();
    run_until(200, 1'b0);
    #2 rst = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("arst_en", 32'(rom_en[i]), 0);
      chk("arst_valid", 32'(col_valid[i]), 0);
      chk("arst_out", {col_out[i], sl_sel[i], char_idx[i], col_idx[i], busy[i],
                       line_done[i], rom_rewind[i]}, 0);
    end
    clear_track();
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    do_start();
    run_to_idle(1'b0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
